// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top: SPI-attached vertex memory with an edge-subdivision kernel.
//
// A host talks SPI mode 0 (MSB first) to a single-port memory of
// 2^ADDR_WIDTH words. Each frame (ss_in low) opens with a command byte:
//   0x01 WRITE  : 16-bit address, then DATA_WIDTH-bit words, auto-increment
//   0x02 READ   : 16-bit address, then words shifted out on miso
//   0x03 START  : 16-bit count N, launches the midpoint kernel
//   0x04 STATUS : next byte on miso is {7'b0, busy}
// The kernel writes mem[2^(ADDR_WIDTH-1)+i] = midpoint(mem[i], mem[i+1])
// for i = 0..N-2, taking three clk cycles per result. While it runs, WRITE,
// READ and START frames are swallowed without touching memory.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   sck_in  in   SPI clock from host (async to clk, clk >= 8x sck)
//   ss_in   in   SPI slave select, active low (async to clk)
//   mosi    in   SPI host-to-device data
//   miso    out  SPI device-to-host data, 0 whenever ss_in is high
//
// Configuration macro: TOP_ROUND_EN
//   defined   -> midpoint = (a+b+1)>>1
//   undefined -> midpoint = (a+b)>>1
// -----------------------------------------------------------------------------
module top #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sck_in,
    input  logic ss_in,
    input  logic mosi,
    output logic miso
);

    localparam int SHIFT_W = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
    localparam int CNT_W   = $clog2(SHIFT_W) + 1;
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int HALF    = 1 << (ADDR_WIDTH - 1);

    localparam logic [CNT_W-1:0]      LAST_BYTE  = CNT_W'(7);
    localparam logic [CNT_W-1:0]      LAST_HWORD = CNT_W'(15);
    localparam logic [CNT_W-1:0]      LAST_WORD  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] OUT_BASE   = ADDR_WIDTH'(HALF);

    typedef enum logic [1:0] {ST_IDLE, ST_RD_A, ST_RD_B, ST_WR} kstate_t;
    typedef enum logic [1:0] {PH_CMD, PH_ADDR, PH_DATA, PH_IGNORE} phase_t;
    typedef enum logic [1:0] {CMD_WRITE, CMD_READ, CMD_START, CMD_OTHER} cmd_t;

    // ------------------------------------------------------------------
    // Input synchronizers and sck edge detection
    // ------------------------------------------------------------------
    logic [1:0] r_sck_sync;
    logic [1:0] r_ss_sync;
    logic [1:0] r_mosi_sync;
    logic       r_sck_prev;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // two-flop synchronizer into a single stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_sync  <= 2'b00;
            r_ss_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sck_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], sck_in};
            r_ss_sync   <= {r_ss_sync[0], ss_in};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sck_prev  <= r_sck_sync[1];
        end
    end

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_ss_active;
    logic w_mosi;

    assign w_sck_rise  =  r_sck_sync[1] & ~r_sck_prev;
    assign w_sck_fall  = ~r_sck_sync[1] &  r_sck_prev;
    assign w_ss_active = ~r_ss_sync[1];
    assign w_mosi      =  r_mosi_sync[1];

    // ------------------------------------------------------------------
    // Shared signals
    // ------------------------------------------------------------------
    kstate_t               r_state;
    kstate_t               w_state_next;
    logic                  w_busy;
    logic [DATA_WIDTH-1:0] r_mem_q;

    assign w_busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // SPI frame decoder
    // ------------------------------------------------------------------
    phase_t                r_phase;
    cmd_t                  r_cmd;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [SHIFT_W-2:0]    r_shift_in;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_blocked;   // frame opened while kernel was busy
    logic                  r_fetch;     // read mem[r_addr] this cycle
    logic                  r_load;      // r_mem_q holds the fetched word
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_miso;

    logic [SHIFT_W-1:0]    w_shift_next;
    logic [7:0]            w_cmd_byte;
    logic [15:0]           w_hword;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_spi_we;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_count;

    // Field values include the bit being sampled on this rising edge.
    assign w_shift_next = {r_shift_in, w_mosi};
    assign w_cmd_byte   = w_shift_next[7:0];
    assign w_hword      = w_shift_next[15:0];
    assign w_word       = w_shift_next[DATA_WIDTH-1:0];

    assign w_spi_we = w_ss_active & w_sck_rise & ~r_blocked &
                      (r_phase == PH_DATA) & (r_cmd == CMD_WRITE) &
                      (r_bit_cnt == LAST_WORD);

    assign w_start  = w_ss_active & w_sck_rise & ~r_blocked &
                      (r_phase == PH_ADDR) & (r_cmd == CMD_START) &
                      (r_bit_cnt == LAST_HWORD);

    assign w_count  = (w_hword > 16'(HALF)) ? OUT_BASE : w_hword[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        // Deasserted ss ends the frame: decode returns to idle.
        if (reset || !w_ss_active) begin
            r_phase    <= PH_CMD;
            r_cmd      <= CMD_OTHER;
            r_bit_cnt  <= '0;
            r_shift_in <= '0;
            r_addr     <= '0;
            r_blocked  <= 1'b0;
            r_fetch    <= 1'b0;
            r_load     <= 1'b0;
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
        end else begin
            r_fetch <= 1'b0;
            r_load  <= r_fetch;

            if (w_sck_fall) begin
                r_miso     <= r_tx_shift[DATA_WIDTH-1];
                r_tx_shift <= r_tx_shift << 1;
            end

            // The fetch/load pipeline finishes two cycles after a rising
            // edge, well before the next falling edge at 8x oversampling.
            if (r_load) begin
                r_tx_shift <= r_mem_q;
            end

            if (w_sck_rise) begin
                r_shift_in <= w_shift_next[SHIFT_W-2:0];
                r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                case (r_phase)
                    PH_CMD: begin
                        if (r_bit_cnt == LAST_BYTE) begin
                            r_bit_cnt <= '0;
                            r_blocked <= w_busy;
                            case (w_cmd_byte)
                                8'h01: begin r_cmd <= CMD_WRITE; r_phase <= PH_ADDR; end
                                8'h02: begin r_cmd <= CMD_READ;  r_phase <= PH_ADDR; end
                                8'h03: begin r_cmd <= CMD_START; r_phase <= PH_ADDR; end
                                8'h04: begin
                                    r_cmd      <= CMD_OTHER;
                                    r_phase    <= PH_IGNORE;
                                    // Busy lands in the last bit of the next byte.
                                    r_tx_shift <= DATA_WIDTH'(w_busy) << (DATA_WIDTH - 8);
                                end
                                default: begin r_cmd <= CMD_OTHER; r_phase <= PH_IGNORE; end
                            endcase
                        end
                    end
                    PH_ADDR: begin
                        if (r_bit_cnt == LAST_HWORD) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_hword[ADDR_WIDTH-1:0];
                            r_phase   <= (r_cmd == CMD_START) ? PH_IGNORE : PH_DATA;
                            if (r_cmd == CMD_READ && !r_blocked) begin
                                r_fetch <= 1'b1;
                            end
                        end
                    end
                    PH_DATA: begin
                        if (r_bit_cnt == LAST_WORD) begin
                            r_bit_cnt <= '0;
                            r_addr    <= r_addr + 1'b1;
                            if (r_cmd == CMD_READ && !r_blocked) begin
                                r_fetch <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign miso = r_miso & ~ss_in;

    // ------------------------------------------------------------------
    // Subdivision kernel FSM
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_n;
    logic [DATA_WIDTH-1:0] r_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_n     <= '0;
            r_a     <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_start) begin
                r_n   <= w_count;
                r_idx <= '0;
            end
            if (r_state == ST_RD_B) begin
                r_a <= r_mem_q;
            end
            if (r_state == ST_WR && w_state_next == ST_RD_A) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default before the
    // case; a path that leaves one unassigned infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start && w_count >= ADDR_WIDTH'(2)) w_state_next = ST_RD_A;
            ST_RD_A: w_state_next = ST_RD_B;
            ST_RD_B: w_state_next = ST_WR;
            ST_WR:   w_state_next = (r_idx < r_n - ADDR_WIDTH'(2)) ? ST_RD_A : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Midpoint computed one bit wider so the carry is kept.
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_mid;

`ifdef TOP_ROUND_EN
    assign w_sum = {1'b0, r_a} + {1'b0, r_mem_q} + (DATA_WIDTH+1)'(1);
`else
    assign w_sum = {1'b0, r_a} + {1'b0, r_mem_q};
`endif
    assign w_mid = w_sum[DATA_WIDTH:1];

    // ------------------------------------------------------------------
    // Single-port memory; kernel owns the port whenever it is running.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    always_comb begin
        w_mem_addr  = r_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = w_word;
        case (r_state)
            ST_RD_A: w_mem_addr = r_idx;
            ST_RD_B: w_mem_addr = r_idx + 1'b1;
            ST_WR: begin
                w_mem_addr  = OUT_BASE | r_idx;
                w_mem_we    = 1'b1;
                w_mem_wdata = w_mid;
            end
            default: w_mem_we = w_spi_we;
        endcase
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset branch: it maps onto block RAM, and its
    // contents must survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        r_mem_q <= r_mem[w_mem_addr];
    end

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top: randomized scoreboard bench for top.
// A host model drives SPI frames; expected miso words are queued when a
// frame is issued and a separate monitor assembles miso bits on sck rising
// edges and compares against the queue. A plain array models the memory,
// and the kernel is modelled as a loop of midpoint computations.
// -----------------------------------------------------------------------------
module tb_top;

    localparam int  AW    = 11;
    localparam int  DW    = 16;
    localparam int  DEPTH = 1 << AW;
    localparam int  BASE  = 1 << (AW - 1);
    localparam time HALF  = 60ns;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic sck_in = 1'b0;
    logic ss_in  = 1'b1;
    logic mosi   = 1'b0;
    logic miso;

    top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .sck_in (sck_in),
        .ss_in  (ss_in),
        .mosi   (mosi),
        .miso   (miso)
    );

    always #5ns clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] val;
        int          w;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    bit          cap_en = 1'b0;
    logic [15:0] model_mem[DEPTH];
    bit          known[DEPTH];
    logic [15:0] wbuf[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mid(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef TOP_ROUND_EN
        s = s + 1;
`endif
        return 16'(s / 2);
    endfunction

    function automatic void model_kernel(input int n, input int limit);
        int nn;
        nn = (n > BASE) ? BASE : n;
        for (int i = 0; i < nn - 1 && i < limit; i++) begin
            model_mem[BASE + i] = mid(model_mem[i], model_mem[i + 1]);
            known[BASE + i]     = known[i] && known[i + 1];
        end
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [15:0] acc;
        int          nb;
        exp_t        e;
        acc = '0;
        nb  = 0;
        forever begin
            @(posedge sck_in);
            if (cap_en) begin
                acc = {acc[14:0], miso};
                nb++;
                if (exp_q.size() == 0) begin
                    check("unexpected_capture", nb, 0);
                    nb  = 0;
                    acc = '0;
                end else if (nb == exp_q[0].w) begin
                    e = exp_q.pop_front();
                    if (e.chk) check(e.name, acc, e.val);
                    nb  = 0;
                    acc = '0;
                end
            end
        end
    end

    // ---------------- SPI host ----------------
    task automatic spi_bits(input logic [15:0] tx, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            #HALF;
            sck_in = 1'b1;
            #HALF;
            sck_in = 1'b0;
        end
    endtask

    task automatic frame_begin();
        ss_in = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        ss_in = 1'b1;
        mosi  = 1'b0;
        #(2 * HALF);
    endtask

    task automatic do_write(input logic [15:0] addr, input int n, input bit blocked, input int partial);
        int a;
        frame_begin();
        spi_bits(16'h0001, 8);
        spi_bits(addr, 16);
        for (int k = 0; k < n; k++) begin
            spi_bits(wbuf[k], 16);
            if (!blocked) begin
                a = (int'(addr) + k) % DEPTH;
                model_mem[a] = wbuf[k];
                known[a]     = 1'b1;
            end
        end
        if (partial > 0) spi_bits(16'hFFFF, partial);
        frame_end();
    endtask

    task automatic do_read(input logic [15:0] addr, input int n, input bit blocked, input string name);
        int a;
        frame_begin();
        spi_bits(16'h0002, 8);
        spi_bits(addr, 16);
        for (int k = 0; k < n; k++) begin
            a = (int'(addr) + k) % DEPTH;
            exp_q.push_back('{$sformatf("%s[%0d]", name, k),
                              blocked ? 16'h0000 : model_mem[a], 16,
                              blocked || known[a]});
        end
        cap_en = 1'b1;
        for (int k = 0; k < n; k++) spi_bits(16'h0000, 16);
        cap_en = 1'b0;
        frame_end();
    endtask

    task automatic do_status(input bit exp_busy, input string name);
        frame_begin();
        spi_bits(16'h0004, 8);
        exp_q.push_back('{name, {15'b0, exp_busy}, 8, 1'b1});
        cap_en = 1'b1;
        spi_bits(16'h0000, 8);
        cap_en = 1'b0;
        frame_end();
    endtask

    task automatic do_start(input logic [15:0] n);
        frame_begin();
        spi_bits(16'h0003, 8);
        spi_bits(n, 16);
        frame_end();
    endtask

    task automatic wait_busy_rise(output int t);
        t = 0;
        while (!dut.w_busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tw, bl, seen, bad_busy, bad_miso, k_abort, addr, n;

        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            known[i]     = 1'b0;
        end

        // Reset for one cycle, then idle bus.
        @(negedge clk);
        reset = 1'b0;
        bad_busy = 0;
        bad_miso = 0;
        repeat (100) begin
            @(negedge clk);
            if (dut.w_busy !== 1'b0) bad_busy++;
            if (miso !== 1'b0) bad_miso++;
        end
        check("idle_busy_cycles", bad_busy, 0);
        check("idle_miso_cycles", bad_miso, 0);

        // Basic write / read-back.
        wbuf[0] = 16'h0010; wbuf[1] = 16'h0020; wbuf[2] = 16'h0031;
        do_write(16'h0000, 3, 1'b0, 0);
        do_read(16'h0000, 3, 1'b0, "rd_basic");

        // START N=1: nothing runs.
        seen = 0;
        fork
            do_start(16'd1);
            repeat (400) begin
                @(negedge clk);
                if (dut.w_busy) seen = 1;
            end
        join
        check("busy_n1", seen, 0);

        // START N=3: busy exactly 6 cycles.
        fork
            do_start(16'd3);
            begin
                wait_busy_rise(tw);
                bl = 0;
                while (dut.w_busy && bl < 4000) begin
                    @(negedge clk);
                    bl++;
                end
            end
        join
        check("busy_rise_n3", tw < 4000, 1);
        check("busy_len_n3", bl, 6);
        model_kernel(3, BASE);
        do_read(16'h0400, 2, 1'b0, "rd_kernel3");

        // Wrapping write and read.
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'h5555;
        do_write(16'h07FF, 2, 1'b0, 0);
        do_read(16'h07FF, 2, 1'b0, "rd_wrap");

        // Long kernel; exercise STATUS and blocked traffic meanwhile.
        do_start(16'd1000);
        model_kernel(1000, BASE);
        do_status(1'b1, "status_busy");
        wbuf[0] = 16'h1234;
        do_write(16'h0000, 1, 1'b1, 0);
        do_read(16'h0000, 2, 1'b1, "rd_blocked");
        tw = 0;
        while (dut.w_busy && tw < 5000) begin
            @(negedge clk);
            tw++;
        end
        check("kernel1000_done", tw < 5000, 1);
        do_status(1'b0, "status_idle");
        do_read(16'h0000, 1, 1'b0, "rd_after_block");
        do_read(16'h0400, 2, 1'b0, "rd_kernel1000");

        // Reset in the middle of an N=100 kernel.
        k_abort = $urandom_range(2, 12);
        for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
        do_write(16'h0000, 16, 1'b0, 0);
        for (int i = 0; i < 16; i++) wbuf[i] = 16'hC000 + 16'(i);
        do_write(16'h0400, 16, 1'b0, 0);
        fork
            do_start(16'd100);
            begin
                wait_busy_rise(tw);
                repeat (3 * k_abort) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("busy_after_reset", dut.w_busy, 0);
                reset = 1'b0;
            end
        join
        check("busy_rise_n100", tw < 4000, 1);
        model_kernel(100, k_abort);
        do_read(16'h0400, 16, 1'b0, "rd_abort");

        // Partial trailing word is discarded.
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222;
        do_write(16'h0100, 2, 1'b0, 0);
        wbuf[0] = 16'h3333;
        do_write(16'h0100, 1, 1'b0, 8);
        do_read(16'h0100, 2, 1'b0, "rd_partial");

        // Unknown command: miso stays 0.
        frame_begin();
        spi_bits(16'h0055, 8);
        exp_q.push_back('{"unknown_cmd", 16'h0000, 16, 1'b1});
        cap_en = 1'b1;
        spi_bits(16'hA5A5, 16);
        cap_en = 1'b0;
        frame_end();

        // Random write/read bursts.
        for (int r = 0; r < 3; r++) begin
            addr = $urandom_range(0, DEPTH - 1);
            n    = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            do_write(16'(addr), n, 1'b0, 0);
            do_read(16'(addr), n, 1'b0, $sformatf("rd_rand%0d", r));
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
